// File: rtl/cdc_word_pkg.sv
// Shared types and constants for the level-toggle word-transfer endpoints.
package cdc_word_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } cdc_word_state_t;

    localparam int CDC_SYNC_BASE_DEPTH = 2;

endpackage

// File: rtl/cdc_bit_sync_arst.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
module cdc_bit_sync_arst #(
    parameter int DEPTH = 2
) (
    input  logic clock,
    input  logic clear_n,
    input  logic async_bit,
    output logic synced_bit
);

    logic [DEPTH-1:0] sync_q;

    // NOTE: non-blocking assignments keep every stage sampling the old value of its
    // predecessor, which is what makes this a shift chain rather than a wire.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], async_bit};
        end
    end

    assign synced_bit = sync_q[DEPTH-1];

endmodule

// File: rtl/cdc_word_responder.sv
// Receiving endpoint of the 2-phase toggle word link; presents words with ready/valid.
// Define CDC_WORD_RESPONDER_EARLY_ACK_EN to acknowledge on capture (allows no-bubble refill).
module cdc_word_responder
    import cdc_word_pkg::*;
#(
    parameter int WORD_WIDTH  = 8,
    parameter int EXTRA_DEPTH = 0,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic                   request_level,
    input  logic [WORD_WIDTH-1:0]  request_data,
    output logic                   acknowledge_level,
    output logic [WORD_WIDTH-1:0]  receiving_data,
    output logic                   receiving_data_valid,
    input  logic                   receiving_data_ready,
    output logic [COUNT_WIDTH-1:0] transfer_count
);

    localparam int SYNC_DEPTH = CDC_SYNC_BASE_DEPTH + EXTRA_DEPTH;

    logic            req_synced;
    logic            req_seen;
    logic            pending;
    cdc_word_state_t state;

    cdc_bit_sync_arst #(
        .DEPTH(SYNC_DEPTH)
    ) u_req_sync (
        .clock      (clock),
        .clear_n    (clear_n),
        .async_bit  (request_level),
        .synced_bit (req_synced)
    );

    // Level compare rather than edge detect: a request cannot be missed while busy.
    assign pending = (req_synced != req_seen);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state                <= IDLE;
            req_seen             <= 1'b0;
            acknowledge_level    <= 1'b0;
            receiving_data       <= '0;
            receiving_data_valid <= 1'b0;
            transfer_count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        receiving_data       <= request_data;
                        req_seen             <= req_synced;
                        receiving_data_valid <= 1'b1;
                        state                <= FULL;
`ifdef CDC_WORD_RESPONDER_EARLY_ACK_EN
                        acknowledge_level    <= ~acknowledge_level;
`endif
                    end
                end
                FULL: begin
                    if (receiving_data_ready) begin
                        transfer_count <= transfer_count + COUNT_WIDTH'(1);
`ifdef CDC_WORD_RESPONDER_EARLY_ACK_EN
                        if (pending) begin
                            receiving_data    <= request_data;
                            req_seen          <= req_synced;
                            acknowledge_level <= ~acknowledge_level;
                        end else begin
                            receiving_data_valid <= 1'b0;
                            state                <= IDLE;
                        end
`else
                        // A request pending here is a sender violation; it stays pending.
                        acknowledge_level    <= ~acknowledge_level;
                        receiving_data_valid <= 1'b0;
                        state                <= IDLE;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
